// File: rtl/tt_dfd_staging_arbiter.sv
// Round-robin arbiter feeding a fixed-latency DFD staging pipeline, with grants
// gated by a credit counter that mirrors the free entries of the downstream sink.
module tt_dfd_staging_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2,
  parameter int CREDITS = 4,
  localparam int SRC_W  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(CREDITS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            hold,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out_data,
  output logic [SRC_W-1:0]                out_src,
  input  logic                            credit_return,
  output logic [CNT_W-1:0]                credit_cnt,
  output logic                            idle,
  output logic                            err_overflow
);

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  // Handshake: requester i transfers on a cycle where req_valid[i] & req_ready[i];
  // req_ready never depends on anything but state, hold, rst and req_valid, and the
  // sink side has no ready: credits guarantee it always has room.
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] credit_cnt_q, credit_cnt_d;
  logic             err_overflow_q, err_overflow_d;
  logic             grant_en;
  logic             grant_any;
  logic [SRC_W-1:0] winner;
  logic [WIDTH-1:0] win_data;
  logic             inflight;

  always_comb begin : grant_comb
    int idx;
    idx       = 0;
    grant_en  = !rst && !hold && (credit_cnt_q != '0);
    grant_any = 1'b0;
    winner    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (grant_en && !grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        winner    = SRC_W'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_any && (winner == SRC_W'(i));
    end
    win_data = req_data[winner];
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    credit_cnt_d   = credit_cnt_q;
    err_overflow_d = err_overflow_q;
    if (grant_any) begin
      rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + SRC_W'(1);
    end
    if (grant_any && !credit_return) begin
      credit_cnt_d = credit_cnt_q - CNT_W'(1);
    end else if (!grant_any && credit_return) begin
      // A return with the counter already full means the sink and this block disagree.
      if (credit_cnt_q == CRED_MAX) err_overflow_d = 1'b1;
      else                          credit_cnt_d   = credit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      credit_cnt_q   <= CRED_MAX;
      err_overflow_q <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      credit_cnt_q   <= credit_cnt_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid = grant_any;
      assign out_data  = win_data;
      assign out_src   = winner;
      assign inflight  = 1'b0;
    end else begin : g_pipe
      logic [DEPTH-1:0] stg_valid_q, stg_valid_d;
      logic [WIDTH-1:0] stg_data_q [DEPTH];
      logic [WIDTH-1:0] stg_data_d [DEPTH];
      logic [SRC_W-1:0] stg_src_q  [DEPTH];
      logic [SRC_W-1:0] stg_src_d  [DEPTH];

      // Payload registers only load behind a valid, so idle stages keep their last value.
      always_comb begin
        stg_valid_d[0] = grant_any;
        stg_data_d[0]  = grant_any ? win_data : stg_data_q[0];
        stg_src_d[0]   = grant_any ? winner   : stg_src_q[0];
        for (int s = 1; s < DEPTH; s++) begin
          stg_valid_d[s] = stg_valid_q[s-1];
          stg_data_d[s]  = stg_valid_q[s-1] ? stg_data_q[s-1] : stg_data_q[s];
          stg_src_d[s]   = stg_valid_q[s-1] ? stg_src_q[s-1]  : stg_src_q[s];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          stg_valid_q <= '0;
          for (int s = 0; s < DEPTH; s++) begin
            stg_data_q[s] <= '0;
            stg_src_q[s]  <= '0;
          end
        end else begin
          stg_valid_q <= stg_valid_d;
          for (int s = 0; s < DEPTH; s++) begin
            stg_data_q[s] <= stg_data_d[s];
            stg_src_q[s]  <= stg_src_d[s];
          end
        end
      end

      assign out_valid = stg_valid_q[DEPTH-1];
      assign out_data  = stg_data_q[DEPTH-1];
      assign out_src   = stg_src_q[DEPTH-1];
      assign inflight  = |stg_valid_q;
    end
  endgenerate

  assign credit_cnt   = credit_cnt_q;
  assign err_overflow = err_overflow_q;
  assign idle         = (credit_cnt_q == CRED_MAX) && !inflight;

endmodule

// File: tb/tb_tt_dfd_staging_arbiter.sv
// Directed bench for tt_dfd_staging_arbiter: a DEPTH=2 instance checked through an
// expected-entry queue drained by an output monitor, plus a DEPTH=0 instance.
module tb_tt_dfd_staging_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int SRC_W   = 2;
  localparam int CNT_W   = 3;
  localparam int EW      = SRC_W + WIDTH;

  logic                          clk;
  logic                          rst;
  logic                          hold;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          out_valid;
  logic [WIDTH-1:0]              out_data;
  logic [SRC_W-1:0]              out_src;
  logic                          credit_return;
  logic [CNT_W-1:0]              credit_cnt;
  logic                          idle;
  logic                          err_overflow;

  logic                          hold0;
  logic [NUM_REQ-1:0]            req_valid0;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data0;
  logic [NUM_REQ-1:0]            req_ready0;
  logic                          out_valid0;
  logic [WIDTH-1:0]              out_data0;
  logic [SRC_W-1:0]              out_src0;
  logic                          credit_return0;
  logic [CNT_W-1:0]              credit_cnt0;
  logic                          idle0;
  logic                          err_overflow0;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [WIDTH-1:0] dtab[NUM_REQ] = '{8'h11, 8'h22, 8'h33, 8'h44};

  tt_dfd_staging_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(2), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .credit_return(credit_return), .credit_cnt(credit_cnt), .idle(idle),
    .err_overflow(err_overflow)
  );

  tt_dfd_staging_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(0), .CREDITS(4)) dut0 (
    .clk(clk), .rst(rst), .hold(hold0), .req_valid(req_valid0), .req_data(req_data0),
    .req_ready(req_ready0), .out_valid(out_valid0), .out_data(out_data0), .out_src(out_src0),
    .credit_return(credit_return0), .credit_cnt(credit_cnt0), .idle(idle0),
    .err_overflow(err_overflow0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete (got running, need finished)");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int src);
    exp_q.push_back({SRC_W'(src), dtab[src]});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got src %0d data %0h, expected no entry", out_src, out_data);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({out_src, out_data} !== e) begin
          errors++;
          $display("FAIL out_entry: got src %0d data %0h expected src %0d data %0h",
                   out_src, out_data, e[EW-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  int seq1[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int seq2[4] = '{1, 3, 1, 3};

  initial begin
    rst = 1'b1; hold = 1'b0; credit_return = 1'b0;
    req_valid = '1;
    req_data  = {dtab[3], dtab[2], dtab[1], dtab[0]};
    hold0 = 1'b0; credit_return0 = 1'b0; req_valid0 = '0;
    req_data0 = {8'h00, 8'hA5, 8'h00, 8'h00};
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_credit_cnt", 32'(credit_cnt), 32'd4);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_err", 32'(err_overflow), 32'h0);

    // DEPTH=0 pass-through
    rst = 1'b0; req_valid = '0; req_valid0 = 4'b0100;
    #1;
    chk("d0_req_ready", 32'(req_ready0), 32'h4);
    chk("d0_out_valid", 32'(out_valid0), 32'h1);
    chk("d0_out_data", 32'(out_data0), 32'hA5);
    chk("d0_out_src", 32'(out_src0), 32'd2);
    chk("d0_cnt_before", 32'(credit_cnt0), 32'd4);
    tick();
    req_valid0 = '0;
    #1;
    chk("d0_cnt_after", 32'(credit_cnt0), 32'd3);
    chk("d0_out_valid_off", 32'(out_valid0), 32'h0);

    // all requesters, credits returned every cycle
    req_valid = '1; credit_return = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_all_grant", 32'(req_ready), 32'(1) << seq1[k]);
      chk("rr_all_cnt", 32'(credit_cnt), 32'd4);
      push(seq1[k]);
      tick();
    end
    req_valid = '0; credit_return = 1'b0;
    repeat (3) tick();
    chk("rr_all_idle", 32'(idle), 32'h1);
    chk("rr_all_err", 32'(err_overflow), 32'h0);

    // requesters 1 and 3, no returns: credits run out
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cred_grant", 32'(req_ready), 32'(1) << seq2[k]);
      chk("cred_cnt", 32'(credit_cnt), 32'(4 - k));
      push(seq2[k]);
      tick();
    end
    chk("cred_exhaust_ready", 32'(req_ready), 32'h0);
    chk("cred_exhaust_cnt", 32'(credit_cnt), 32'd0);
    tick();
    chk("cred_exhaust_ready2", 32'(req_ready), 32'h0);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    #1;
    chk("cred_one_cnt", 32'(credit_cnt), 32'd1);
    chk("cred_one_grant", 32'(req_ready), 32'h2);
    push(1);
    tick();
    req_valid = '0;
    chk("cred_zero_again", 32'(credit_cnt), 32'd0);
    credit_return = 1'b1;
    repeat (4) tick();
    credit_return = 1'b0;
    tick();
    chk("cred_refill_cnt", 32'(credit_cnt), 32'd4);
    chk("cred_refill_idle", 32'(idle), 32'h1);

    // overflow is sticky
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("ovf_set", 32'(err_overflow), 32'h1);
    chk("ovf_cnt", 32'(credit_cnt), 32'd4);
    repeat (3) tick();
    chk("ovf_sticky", 32'(err_overflow), 32'h1);

    // hold mid-stream: rr_ptr is at 2
    req_valid = '1;
    #1;
    chk("hold_pre_grant2", 32'(req_ready), 32'h4);
    push(2);
    tick();
    chk("hold_pre_grant3", 32'(req_ready), 32'h8);
    push(3);
    tick();
    hold = 1'b1;
    #1;
    chk("hold_no_grant", 32'(req_ready), 32'h0);
    chk("hold_cnt", 32'(credit_cnt), 32'd2);
    chk("hold_not_idle", 32'(idle), 32'h0);
    credit_return = 1'b1;
    repeat (2) tick();
    credit_return = 1'b0;
    chk("hold_no_grant2", 32'(req_ready), 32'h0);
    chk("hold_cnt_back", 32'(credit_cnt), 32'd4);
    chk("hold_idle", 32'(idle), 32'h1);
    chk("hold_err_sticky", 32'(err_overflow), 32'h1);

    // reset with entries in flight: rr_ptr is at 0
    hold = 1'b0;
    #1;
    chk("rstmid_grant0", 32'(req_ready), 32'h1);
    push(0);
    tick();
    chk("rstmid_grant1", 32'(req_ready), 32'h2);
    tick();
    chk("rstmid_cnt", 32'(credit_cnt), 32'd2);
    rst = 1'b1;
    tick();
    chk("rstmid_out_valid", 32'(out_valid), 32'h0);
    chk("rstmid_cnt_after", 32'(credit_cnt), 32'd4);
    chk("rstmid_idle", 32'(idle), 32'h1);
    chk("rstmid_err_clear", 32'(err_overflow), 32'h0);
    chk("rstmid_ready_in_rst", 32'(req_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("rstmid_ptr_zero", 32'(req_ready), 32'h1);
    req_valid = '0;
    repeat (4) tick();
    chk("rstmid_no_grant_cnt", 32'(credit_cnt), 32'd4);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
